// File: rtl/mux_sel_ctrl.sv
// rtl/mux_sel_ctrl.sv - select-line controller for the 2:1 mux stage
//
// Synchronizes and debounces a raw pushbutton and toggles the mux select on
// each clean press. An optional auto mode toggles the select periodically.
// Every select change is flagged with a one-cycle pulse.
//
// Ports:
//   clk        system clock, rising-edge
//   reset      asynchronous, active-high reset
//   btn        raw pushbutton, asynchronous to clk, may bounce
//   auto_en    1 = periodic auto-toggle enabled (used unsynchronized)
//   s          registered mux select (0 = x, 1 = y)
//   s_changed  one-cycle pulse in the cycle after s changes
//   btn_clean  debounced, synchronized button level
module mux_sel_ctrl #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_PERIOD     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    input  logic auto_en,
    output logic s,
    output logic s_changed,
    output logic btn_clean
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int PW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PW-1:0] P_LAST  = PW'(AUTO_PERIOD - 1);

    typedef enum logic [1:0] {
        STABLE_LOW,
        WAIT_HIGH,
        STABLE_HIGH,
        WAIT_LOW
    } db_state_t;

    logic          sync1;
    logic          btn_sync;
    db_state_t     state;
    db_state_t     state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic          clean_nx;
    logic          clean_d;
    logic          press;
    logic [PW-1:0] pcnt;
    logic          tick;
    logic          toggle;

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1    <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            sync1    <= btn;
            btn_sync <= sync1;
        end
    end

    // Debounce FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= STABLE_LOW;
            cnt       <= '0;
            btn_clean <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            btn_clean <= clean_nx;
        end
    end

    // Debounce FSM next-state logic. The first sample at the new level counts
    // as sample 1, so a single-cycle debounce accepts straight from the
    // stable state.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        clean_nx = btn_clean;
        case (state)
            STABLE_LOW: begin
                if (btn_sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nx = STABLE_HIGH;
                        clean_nx = 1'b1;
                        cnt_nx   = '0;
                    end else begin
                        state_nx = WAIT_HIGH;
                        cnt_nx   = CW'(1);
                    end
                end
            end
            WAIT_HIGH: begin
                if (!btn_sync) begin
                    state_nx = STABLE_LOW;
                    cnt_nx   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nx = STABLE_HIGH;
                    clean_nx = 1'b1;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            STABLE_HIGH: begin
                if (!btn_sync) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        state_nx = STABLE_LOW;
                        clean_nx = 1'b0;
                        cnt_nx   = '0;
                    end else begin
                        state_nx = WAIT_LOW;
                        cnt_nx   = CW'(1);
                    end
                end
            end
            WAIT_LOW: begin
                if (btn_sync) begin
                    state_nx = STABLE_HIGH;
                    cnt_nx   = '0;
                end else if (cnt == DB_LAST) begin
                    state_nx = STABLE_LOW;
                    clean_nx = 1'b0;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CW'(1);
                end
            end
            default: begin
                state_nx = STABLE_LOW;
                cnt_nx   = '0;
                clean_nx = 1'b0;
            end
        endcase
    end

    // Press = rising edge of the debounced level; releases are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clean_d <= 1'b0;
        end else begin
            clean_d <= btn_clean;
        end
    end

    assign press = btn_clean & ~clean_d;

    // Auto-toggle period counter; disabling clears it so a re-enable always
    // waits a full period before the next tick.
    assign tick = auto_en && (pcnt == P_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcnt <= '0;
        end else if (!auto_en || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PW'(1);
        end
    end

    // A press coinciding with a tick yields a single toggle
    assign toggle = press | tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s         <= 1'b0;
            s_changed <= 1'b0;
        end else begin
            if (toggle) begin
                s <= ~s;
            end
            s_changed <= toggle;
        end
    end

endmodule

// File: doc/mux_sel_ctrl.md
Name: mux_sel_ctrl

Overview:
Select-line controller that drives the `s` input of the team's 2:1 mux stage. It takes a raw pushbutton, synchronizes and debounces it, and toggles `s` on each clean press. An optional auto mode toggles `s` periodically. It also flags every select change so downstream logic knows the mux output source has switched.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronized samples required to accept a new button level (>=1)
AUTO_PERIOD, 8, clock cycles between automatic toggles of s when auto_en=1 (>=2)

Ports:
clk  input  1  system clock, all state rising-edge triggered
reset  input  1  asynchronous, active-high reset
btn  input  1  raw pushbutton, asynchronous to clk, may bounce
auto_en  input  1  1 = periodic auto-toggle enabled; sampled directly, no synchronizer
s  output  1  registered mux select; 0 selects x, 1 selects y
s_changed  output  1  registered one-cycle pulse, high in the cycle immediately after s changes
btn_clean  output  1  debounced, synchronized button level

Behaviour:
- Reset:
  - Asynchronous reset, active while reset=1.
  - s=0, s_changed=0, btn_clean=0.
  - Both synchronizer flops=0, debounce counter=0, period counter=0.
  - Debounce FSM=STABLE_LOW.
  - Asserting reset mid-debounce or mid-period aborts the operation immediately; no toggle occurs on reset release.
- Synchronizer: 2-flop chain on btn; the output is btn_sync. btn_sync reflects btn 2 edges after btn is first sampled.
- Debounce FSM (states STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW):
  - STABLE_LOW: btn_clean=0. If btn_sync=1, go to WAIT_HIGH and set counter=1.
  - WAIT_HIGH: if btn_sync=0, return to STABLE_LOW and clear the counter. Else if counter==DEBOUNCE_CYCLES-1, go to STABLE_HIGH and set btn_clean=1. Else increment the counter.
  - STABLE_HIGH and WAIT_LOW: mirror images of the above with levels inverted.
  - Net latency: btn_clean changes on edge DEBOUNCE_CYCLES+2 after btn is first sampled stable at the new level.
  - A glitch shorter than DEBOUNCE_CYCLES synchronized samples produces no change on btn_clean.
  - Counter width = clog2(DEBOUNCE_CYCLES)+1; no wrap is possible.
- Press detect: press = btn_clean rising edge (btn_clean=1 and its previous-cycle value = 0). Releases have no effect.
- Auto mode:
  - Period counter runs 0..AUTO_PERIOD-1 while auto_en=1, incrementing every edge.
  - At count AUTO_PERIOD-1 it asserts tick and wraps to 0.
  - auto_en=0 clears the counter to 0 synchronously and suppresses tick.
  - The first tick occurs on the AUTO_PERIOD-th edge with auto_en high.
- Toggle:
  - On an edge where press or tick is true, s <= ~s and s_changed <= 1. Otherwise s_changed <= 0.
  - Press toggle latency: s changes one edge after btn_clean rises, i.e. DEBOUNCE_CYCLES+3 edges after btn.
  - Press and tick in the same cycle produce exactly ONE toggle (logical OR, never a double flip); the period counter still wraps to 0.
  - Back-to-back ticks/presses in consecutive cycles each toggle s, and s_changed stays high for each.
- Holding the button produces only one toggle; no auto-repeat.

Test Plan:
- Reset: assert reset mid-run with btn=1 and auto_en=1 -> s=0, s_changed=0, btn_clean=0 asynchronously; after release with btn=0 and auto_en=0, outputs stay 0 for 20 cycles.
- Clean press (defaults): btn 0->1 held 10 cycles, auto_en=0 -> btn_clean=1 on edge 6, s 0->1 on edge 7, s_changed=1 for exactly that one cycle; releasing btn leaves s=1.
- Bounce rejection: btn pulses high 3 cycles, low 1, high 2, then low -> btn_clean stays 0, s stays 0, s_changed never asserted.
- Auto mode: auto_en=1 for 32 cycles from reset release -> s toggles on edges 8, 16, 24, 32 (0,1,0,1,0 pattern); s_changed pulses 4 times; auto_en=0 then freezes s.
- Collision: align btn_clean rise with the auto tick edge -> s toggles once (0->1, not 0->0), single s_changed pulse, next tick 8 cycles later.
- Auto disable mid-period: auto_en=1 for 5 cycles, 0 for 3, then 1 -> next toggle 8 edges after re-enable, not 3.
